pipe_scroller: RTL

- Parametrised obstacle engine for the flappy-bird game; generalises the fixed three-pipe set to NUM_PIPES channels.
- Adds selectable scroll speed, LFSR-randomised gap position, and a score-increment pulse.
- Sits between control and display. Its packed pipe bus replaces the individual pipe1/pipe2/pipe3 words.

---
 rtl/pipe_scroller.sv | 108 ++++++++++
 1 files changed

// File: rtl/pipe_scroller.sv
// pipe_scroller: scrolling pipe obstacle engine; define PIPE_SHRINK_EN to shrink the gap every 8th respawn
module pipe_scroller #(
  parameter int NUM_PIPES    = 3,
  parameter int SCREEN_W     = 640,
  parameter int PIPE_WIDTH   = 52,
  parameter int PIPE_SPACING = 240,
  parameter int GAP_H        = 120,
  parameter int GAP_MIN      = 40,
  parameter int GAP_MAX      = 320,
  parameter int BIRD_X       = 160,
  parameter int TICK_DIV     = 500000,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      run,
  input  logic [1:0]                speed,
  output logic [32*NUM_PIPES-1:0]   pipes,
  output logic                      score_inc,
  output logic                      tick
);
  localparam int RANGE = GAP_MAX - GAP_MIN;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GAP_MID = (GAP_MIN + GAP_MAX) / 2;
  logic [11:0] x_q [NUM_PIPES];
  logic [11:0] x_d [NUM_PIPES];
  logic [11:0] mv [NUM_PIPES];
  logic [9:0] top_q [NUM_PIPES];
  logic [9:0] top_d [NUM_PIPES];
  logic [9:0] bot_q [NUM_PIPES];
  logic [9:0] bot_d [NUM_PIPES];
  logic [NUM_PIPES-1:0] resp;
  logic [TW-1:0] cnt_q;
  logic tick_q, score_q, move, any_resp, hit;
  logic [15:0] lfsr_q;
  logic [11:0] step;
  logic [9:0] r, gap_new, h_d;
`ifdef PIPE_SHRINK_EN
  logic [2:0] rc_q, rc_d;
  logic [9:0] h_q;
  // every 8th respawning tick narrows the gap by 4, never below 64
  always_comb begin
    rc_d = any_resp ? rc_q + 3'd1 : rc_q;
    h_d = (any_resp && rc_q == 3'd7) ? ((h_q >= 10'd68) ? h_q - 10'd4 : 10'd64) : h_q;
  end
  // respawn counter and gap height
  always_ff @(posedge clk) begin
    if (rst) begin
      rc_q <= '0;
      h_q <= 10'(GAP_H);
    end else begin
      rc_q <= rc_d;
      h_q <= h_d;
    end
  end
`else
  assign h_d = 10'(GAP_H);
`endif
  // movement, respawn placement, random gap and crossing detection
  always_comb begin
    step = {10'd0, speed} + 12'd1;
    move = tick_q & run;
    r = ({1'b0, lfsr_q[8:0]} <= 10'(RANGE)) ? {1'b0, lfsr_q[8:0]} : {1'b0, lfsr_q[8:0]} - 10'(RANGE + 1);
    gap_new = (r <= 10'(RANGE)) ? 10'(GAP_MIN) + r : 10'(GAP_MAX);
    hit = 1'b0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      resp[i] = !(x_q[i] >= step && x_q[i] + 12'(PIPE_WIDTH) > step);
      mv[i] = x_q[i] - step;
      hit = hit | (!resp[i] && x_q[i] + 12'(PIPE_WIDTH) >= 12'(BIRD_X) && mv[i] + 12'(PIPE_WIDTH) < 12'(BIRD_X));
    end
    any_resp = move & |resp;
    for (int i = 0; i < NUM_PIPES; i++) begin
      x_d[i] = !move ? x_q[i] : resp[i] ? mv[(i + NUM_PIPES - 1) % NUM_PIPES] + 12'(PIPE_SPACING) : mv[i];
      top_d[i] = (move && resp[i]) ? gap_new : top_q[i];
      bot_d[i] = (move && resp[i]) ? gap_new + h_d : bot_q[i];
    end
  end
  // state registers, tick divider and free-running LFSR
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PIPES; i++) begin
        x_q[i] <= 12'(SCREEN_W + i * PIPE_SPACING);
        top_q[i] <= 10'(GAP_MID);
        bot_q[i] <= 10'(GAP_MID + GAP_H);
      end
      cnt_q <= '0;
      tick_q <= 1'b0;
      score_q <= 1'b0;
      lfsr_q <= LFSR_SEED;
    end else begin
      x_q <= x_d;
      top_q <= top_d;
      bot_q <= bot_d;
      cnt_q <= (cnt_q == TW'(TICK_DIV - 1)) ? '0 : cnt_q + 1'b1;
      tick_q <= (cnt_q == TW'(TICK_DIV - 1));
      score_q <= move & hit;
      lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end
  end
  genvar g;
  generate
    for (g = 0; g < NUM_PIPES; g++) begin : g_out
      assign pipes[32*g +: 32] = {x_q[g] < 12'(SCREEN_W), x_q[g][10:0], top_q[g], bot_q[g]};
    end
  endgenerate
  assign tick = tick_q;
  assign score_inc = score_q;
endmodule
